random_strobe_gen: RTL

RANDOM_STROBE_GEN -- requirements
Module: random_strobe_gen

---
 rtl/random_strobe_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/random_strobe_gen.sv
// Random-interval strobe generator: a 16-bit Galois LFSR sets each interval to
// min_gap plus a pseudo-random slice, and a one-cycle strobe marks its end.
module random_strobe_gen #(
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [15:0]      seed,
    input  logic [GAP_W-1:0] min_gap,
    output logic             random,
    output logic             rand_bit,
    output logic             busy,
    output logic [7:0]       strobe_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        FIRE  = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    state_t           state_q;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_d;
    logic [15:0]      seed_d;
    logic [GAP_W:0]   cnt_q;
    logic [GAP_W:0]   gap_d;
    logic             random_q;
    logic             rand_bit_q;
    logic             busy_q;
    logic [7:0]       strobe_cnt_q;

    // A zero seed would lock the LFSR at zero, so it is replaced by the default.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        seed_d = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
        gap_d  = {1'b0, min_gap} + {1'b0, lfsr_q[GAP_W-1:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lfsr_q       <= LFSR_DEFAULT;
            cnt_q        <= '0;
            random_q     <= 1'b0;
            rand_bit_q   <= 1'b0;
            busy_q       <= 1'b0;
            strobe_cnt_q <= 8'd0;
        end else begin
            if (seed_load) begin
                lfsr_q <= seed_d;
            end else if (state_q == LOAD) begin
                lfsr_q <= lfsr_d;
            end

            random_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        // gap_d uses the LFSR value from before this cycle's advance
                        cnt_q   <= gap_d;
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q      <= FIRE;
                        random_q     <= 1'b1;
                        rand_bit_q   <= lfsr_q[15];
                        strobe_cnt_q <= strobe_cnt_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIRE: begin
                    if (enable) begin
                        state_q <= LOAD;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign random     = random_q;
    assign rand_bit   = rand_bit_q;
    assign busy       = busy_q;
    assign strobe_cnt = strobe_cnt_q;

endmodule
